// File: rtl/btn_step_req_pkg.sv
// Shared encodings for the single-step button request path.
// The clock controller decodes BTN_OK with the same button constants.
package btn_step_req_pkg;

  localparam int NBTN = 4;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PRESS_DB = 3'd1,
    S_READY    = 3'd2,
    S_REL_WAIT = 3'd3,
    S_REL_DB   = 3'd4
  } state_e;

  localparam logic [NBTN-1:0] BTN_NONE = 4'b0000;
  localparam logic [NBTN-1:0] BTN_1    = 4'b0001;
  localparam logic [NBTN-1:0] BTN_2    = 4'b0010;
  localparam logic [NBTN-1:0] BTN_3    = 4'b0100;
  localparam logic [NBTN-1:0] BTN_4    = 4'b1000;

  // Isolate the lowest set bit; bit 0 wins on simultaneous presses.
  function automatic logic [NBTN-1:0] lsb_onehot(
    input logic [NBTN-1:0] v
  );
    return v & (~v + NBTN'(1));
  endfunction

endpackage

// File: rtl/btn_step_req_debounce_cnt.sv
// Button synchroniser plus saturating stability counter.
// cnt counts edges on which the synchronised level did not change.
module debounce_cnt
  import btn_step_req_pkg::*;
#(
  parameter int DB_CYCLES = 1_000_000,
  parameter int CNT_W     = 20
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NBTN-1:0] btn_in,
  output logic [NBTN-1:0] btn_s,
  output logic            stable
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DB_CYCLES);

  logic [NBTN-1:0]  s1_q;
  logic [NBTN-1:0]  s2_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // s1_q is next cycle's btn_s, so a change clears cnt as btn_s moves.
  always_comb begin
    cnt_d = cnt_q;
    if (s1_q != s2_q) begin
      cnt_d = '0;
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q  <= '0;
      s2_q  <= '0;
      cnt_q <= '0;
    end else begin
      s1_q  <= btn_in;
      s2_q  <= s1_q;
      cnt_q <= cnt_d;
    end
  end

  assign btn_s  = s2_q;
  assign stable = (cnt_q == CntMax);

endmodule

// File: rtl/btn_step_req.sv
// Debounced one-hot button request with keyReady/readn handshake.
// Rearms only after every button has been stably released.
module btn_step_req
  import btn_step_req_pkg::*;
#(
  parameter int DB_CYCLES = 1_000_000,
  parameter int CNT_W     = 20
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NBTN-1:0] btn_in,
  input  logic            readn,
  output logic            keyReady,
  output logic [NBTN-1:0] BTN_OK
);

  logic [NBTN-1:0] btn_s;
  logic            stable;

  state_e          state_q;
  logic            key_ready_q;
  logic [NBTN-1:0] btn_ok_q;

  debounce_cnt #(
    .DB_CYCLES(DB_CYCLES),
    .CNT_W    (CNT_W)
  ) u_db (
    .clk   (clk),
    .rst   (rst),
    .btn_in(btn_in),
    .btn_s (btn_s),
    .stable(stable)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      key_ready_q <= 1'b0;
      btn_ok_q    <= BTN_NONE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (btn_s != BTN_NONE) state_q <= S_PRESS_DB;
        end
        S_PRESS_DB: begin
          if (btn_s == BTN_NONE) begin
            state_q <= S_IDLE;
          end else if (stable) begin
            key_ready_q <= 1'b1;
            btn_ok_q    <= lsb_onehot(btn_s);
            state_q     <= S_READY;
          end
        end
        S_READY: begin
          // X on readn compares false and is ignored.
          if (readn == 1'b0) begin
            key_ready_q <= 1'b0;
            btn_ok_q    <= BTN_NONE;
            state_q     <= S_REL_WAIT;
          end
        end
        S_REL_WAIT: begin
          if (btn_s == BTN_NONE) state_q <= S_REL_DB;
        end
        S_REL_DB: begin
          if (btn_s != BTN_NONE) begin
            state_q <= S_REL_WAIT;
          end else if (stable) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          key_ready_q <= 1'b0;
          btn_ok_q    <= BTN_NONE;
        end
      endcase
    end
  end

  assign keyReady = key_ready_q;
  assign BTN_OK   = btn_ok_q;

endmodule

// File: tb/tb_btn_step_req.sv
// Directed bench for btn_step_req with DB_CYCLES = 8.
// Inputs change on the falling edge; outputs sampled 1 ns after rising.
module tb_btn_step_req;

  logic       clk;
  logic       rst;
  logic [3:0] btn_in;
  logic       readn;
  logic       keyReady;
  logic [3:0] BTN_OK;

  int checks;
  int errors;

  btn_step_req #(
    .DB_CYCLES(8),
    .CNT_W    (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .btn_in  (btn_in),
    .readn   (readn),
    .keyReady(keyReady),
    .BTN_OK  (BTN_OK)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst    = 1'b1;
    btn_in = 4'b0000;
    readn  = 1'b1;
    #12;
    checks++;
    if (keyReady !== 1'b0 || BTN_OK !== 4'b0000) begin
      errors++;
      $display("FAIL reset: kr=%b ok=%b want 0/0000", keyReady, BTN_OK);
    end
    @(negedge clk);
    rst = 1'b0;
    tick(20);
    checks++;
    if (keyReady !== 1'b0 || BTN_OK !== 4'b0000) begin
      errors++;
      $display("FAIL idle: kr=%b ok=%b want 0/0000", keyReady, BTN_OK);
    end
  endtask

  task automatic test_clean_press;
    @(negedge clk);
    btn_in = 4'b0010;
    tick(10);
    checks++;
    if (keyReady !== 1'b0) begin
      errors++;
      $display("FAIL press_early: kr=%b want 0 at cycle 10", keyReady);
    end
    tick(1);
    checks++;
    if (keyReady !== 1'b1 || BTN_OK !== 4'b0010) begin
      errors++;
      $display("FAIL press: kr=%b ok=%b want 1/0010", keyReady, BTN_OK);
    end
    for (int i = 0; i < 6; i++) begin
      tick(1);
      checks++;
      if (keyReady !== 1'b1 || BTN_OK !== 4'b0010) begin
        errors++;
        $display("FAIL press_hold: kr=%b ok=%b want 1/0010", keyReady, BTN_OK);
      end
    end
  endtask

  task automatic test_ack_pulse;
    @(negedge clk);
    readn = 1'b0;
    @(negedge clk);
    readn = 1'b1;
    checks++;
    if (keyReady !== 1'b0 || BTN_OK !== 4'b0000) begin
      errors++;
      $display("FAIL ack_pulse: kr=%b ok=%b want 0/0000", keyReady, BTN_OK);
    end
  endtask

  task automatic test_release_repress;
    tick(30);
    checks++;
    if (keyReady !== 1'b0) begin
      errors++;
      $display("FAIL held_after_ack: kr=%b want 0", keyReady);
    end
    @(negedge clk);
    btn_in = 4'b0000;
    repeat (4) @(posedge clk);
    @(negedge clk);
    btn_in = 4'b0010;
    for (int i = 0; i < 25; i++) begin
      tick(1);
      checks++;
      if (keyReady !== 1'b0) begin
        errors++;
        $display("FAIL short_release: kr=%b want 0 cycle %0d", keyReady, i);
      end
    end
    @(negedge clk);
    btn_in = 4'b0000;
    tick(20);
    @(negedge clk);
    btn_in = 4'b0001;
    tick(10);
    checks++;
    if (keyReady !== 1'b0) begin
      errors++;
      $display("FAIL repress_early: kr=%b want 0", keyReady);
    end
    tick(1);
    checks++;
    if (keyReady !== 1'b1 || BTN_OK !== 4'b0001) begin
      errors++;
      $display("FAIL repress: kr=%b ok=%b want 1/0001", keyReady, BTN_OK);
    end
  endtask

  task automatic test_ack_hold;
    @(negedge clk);
    readn = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      checks++;
      if (keyReady !== 1'b0 || BTN_OK !== 4'b0000) begin
        errors++;
        $display("FAIL ack_hold: kr=%b ok=%b want 0/0000", keyReady, BTN_OK);
      end
    end
    @(negedge clk);
    readn  = 1'b1;
    btn_in = 4'b0000;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      checks++;
      if (keyReady !== 1'b0) begin
        errors++;
        $display("FAIL ack_hold_after: kr=%b want 0 cycle %0d", keyReady, i);
      end
    end
  endtask

  task automatic test_bounce;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (i % 3 == 0) btn_in[0] = ~btn_in[0];
      tick(1);
      checks++;
      if (keyReady !== 1'b0) begin
        errors++;
        $display("FAIL bounce: kr=%b want 0 cycle %0d", keyReady, i);
      end
    end
    @(negedge clk);
    btn_in = 4'b0000;
    tick(20);
    checks++;
    if (keyReady !== 1'b0 || BTN_OK !== 4'b0000) begin
      errors++;
      $display("FAIL bounce_end: kr=%b ok=%b want 0/0000", keyReady, BTN_OK);
    end
  endtask

  task automatic test_simultaneous;
    @(negedge clk);
    btn_in = 4'b1100;
    tick(11);
    checks++;
    if (keyReady !== 1'b1 || BTN_OK !== 4'b0100) begin
      errors++;
      $display("FAIL simul: kr=%b ok=%b want 1/0100", keyReady, BTN_OK);
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (keyReady !== 1'b0 || BTN_OK !== 4'b0000) begin
      errors++;
      $display("FAIL async_rst: kr=%b ok=%b want 0/0000", keyReady, BTN_OK);
    end
    @(negedge clk);
    rst = 1'b0;
    tick(10);
    checks++;
    if (keyReady !== 1'b0) begin
      errors++;
      $display("FAIL rst_press_early: kr=%b want 0", keyReady);
    end
    @(negedge clk);
    readn = 1'b0;
    tick(1);
    checks++;
    if (keyReady !== 1'b1 || BTN_OK !== 4'b0100) begin
      errors++;
      $display("FAIL rst_press: kr=%b ok=%b want 1/0100", keyReady, BTN_OK);
    end
    @(negedge clk);
    readn = 1'b1;
    tick(1);
    checks++;
    if (keyReady !== 1'b1 || BTN_OK !== 4'b0100) begin
      errors++;
      $display("FAIL entry_ack: kr=%b ok=%b want 1/0100", keyReady, BTN_OK);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset;
    test_clean_press;
    test_ack_pulse;
    test_release_repress;
    test_ack_hold;
    test_bounce;
    test_simultaneous;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/btn_step_req.md
# btn_step_req

Debounced push-button request generator driving the CPU single-step clock controller. Synchronises and debounces four raw buttons, captures the first stable press as a one-hot code on `BTN_OK` and raises `keyReady`. It holds the request until the controller acknowledges with an active-low `readn` pulse, then rearms only after all buttons are stably released. It sits between the board button pins and the clock divider, as the request side of the `keyReady`/`BTN_OK`/`readn` handshake.

## Interface
- `DB_CYCLES`, default 1_000_000: consecutive stable cycles required to accept a press or release (10 ms at 100 MHz). Must be ≥ 2.
- `CNT_W`, default 20: debounce counter width. Must satisfy 2^CNT_W > DB_CYCLES.
- `clk`  input  1  system clock; all state is updated on its rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `btn_in`  input  4  raw, asynchronous, active-high button levels.
- `readn`  input  1  acknowledge from the clock controller, active low. Only meaningful while `keyReady` = 1; X or 1 elsewhere is ignored.
- `keyReady`  output  1  request valid, registered level.
- `BTN_OK`  output  4  one-hot button code, registered. Valid whenever `keyReady` = 1, otherwise 0.

## Operation
- **Synchroniser:** two flops on `btn_in`, giving `btn_s`. No other logic touches `btn_in`.
- **Debounce counter:** `cnt` is reset to 0 whenever `btn_s` differs from its previous-cycle value. Otherwise it increments and saturates at DB_CYCLES. "Stable" means `cnt` == DB_CYCLES.
- **FSM states:**
  - IDLE: all released. If `btn_s` != 0, go to PRESS_DB.
  - PRESS_DB: if `btn_s` == 0, return to IDLE. If stable and nonzero, capture, set `keyReady`, and go to READY.
  - READY: hold `keyReady` = 1 and `BTN_OK` constant. When `readn` == 0 is sampled, clear `keyReady` and `BTN_OK` and go to REL_WAIT.
  - REL_WAIT: when `btn_s` == 0, go to REL_DB.
  - REL_DB: if `btn_s` != 0, return to REL_WAIT. If stable at 0, go to IDLE.
- **Capture:** `BTN_OK` gets the lowest-indexed set bit of `btn_s`, one-hot (bit 0 highest priority). Simultaneous presses therefore yield exactly one bit.
- `BTN_OK` and `keyReady` change in the same cycle. `BTN_OK` is never nonzero while `keyReady` = 0.
- **In READY:** presses, releases and extra buttons are ignored. Buttons released before the ack are fine; REL_WAIT then passes straight through.
- No timeout: READY persists indefinitely without an ack.
- **Reset:** asynchronous in any state. State goes to IDLE; `keyReady` = 0, `BTN_OK` = 0, `cnt` = 0, synchroniser flops = 0. A button held through reset deassertion is treated as a new press and is accepted after debounce.

## Timing
- **Press-to-request latency:** 2 synchroniser cycles + DB_CYCLES cycles + 1 register cycle from a clean `btn_in` edge.
- **Ack-to-drop latency:** `readn` sampled low at edge N gives `keyReady` = 0 after edge N. A one-cycle `readn` pulse is sufficient. A `readn` held low for many cycles is treated as a single ack.
- `readn` low in the same cycle `keyReady` first rises is not an ack. Only `readn` sampled while already in READY counts, i.e. from the edge after entry.
- **Minimum spacing between requests:** drop of `keyReady`, then release debounce of DB_CYCLES+1 cycles, then press debounce.
- Bounce shorter than DB_CYCLES never produces a request or a false release.

## Structure
- **Shared package:** FSM state encoding (IDLE, PRESS_DB, READY, REL_WAIT, REL_DB, 3 bits) and the button-code constants BTN_1=4'b0001 … BTN_4=4'b1000. The clock controller decodes `BTN_OK` with the same constants.
- **One sub-module, `debounce_cnt`:** holds the synchroniser, the change detector and the saturating counter. Outputs are `btn_s` and `stable`. The FSM, capture and handshake stay in the top.

## Test plan
All tests use DB_CYCLES = 8.
- **Clean press:** `btn_in` = 4'b0010 held. Required: `keyReady` = 1 and `BTN_OK` = 4'b0010 exactly 11 cycles after the edge, holding until ack.
- **Bounce:** toggle `btn_in[0]` every 3 cycles for 30 cycles, then release. Required: `keyReady` stays 0 throughout.
- **Simultaneous press:** `btn_in` = 4'b1100. Required: `BTN_OK` = 4'b0100.
- **Ack:**
  - 1-cycle `readn` = 0 pulse while in READY: `keyReady` and `BTN_OK` = 0 the next cycle.
  - Button still held, then a second press: no new request until a debounced release, then a fresh press.
  - `readn` low held for 5 cycles: yields one drop only.
- **Reset mid-operation:** assert `rst` while in READY. Required: `keyReady` = 0 and `BTN_OK` = 0 immediately (asynchronous). With the button still held after deassertion, a new request 11 cycles later.
- **Release re-press:** after ack, release for 4 cycles, then re-press. Required: no request until the release has been stable for 8 cycles, followed by a full press debounce.
